// File: rtl/stk_pkg.sv
// Shared descriptor types for the stack allocator return path.
package stk_pkg;
  localparam int RT_PORTS_N = 2;
  localparam int BANK_W     = 2;
  localparam int LINE_W     = 6;

  typedef logic [BANK_W-1:0] bank_id_t;
  typedef logic [LINE_W-1:0] line_id_t;

  typedef struct packed {
    bank_id_t bnk_id;
    line_id_t line_id;
  } ptr_t;
endpackage

// File: rtl/stk_pipe_dl_buf.sv
// 2-write/1-read descriptor queue; head falls through to the first pushed
// entry while empty so an idle buffer adds no latency.
module stk_pipe_dl_buf
  import stk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [RT_PORTS_N-1:0]   i_push,
  input  ptr_t [RT_PORTS_N-1:0]   i_wdata,
  input  logic                    i_pop,
  output ptr_t                    o_rdata,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_cnt_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  ptr_t          r_mem [DEPTH];
  ptr_t          w_wd0;
  logic [1:0]    w_npush;

  // A lone port-1 push takes the first free slot.
  assign w_wd0     = i_push[0] ? i_wdata[0] : i_wdata[1];
  assign w_npush   = {1'b0, i_push[0]} + {1'b0, i_push[1]};
  assign o_empty   = (r_cnt == '0);
  assign o_cnt_nxt = r_cnt + CW'(w_npush) - CW'(i_pop);
  assign o_rdata   = o_empty ? w_wd0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (|i_push) r_mem[r_wr] <= w_wd0;
    if (&i_push) r_mem[r_wr + AW'(1)] <= i_wdata[1];
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_npush);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= o_cnt_nxt;
    end
  end
endmodule

// File: rtl/stk_pipe_dl.sv
// Retired-descriptor return pipe: buffers up to two retires per cycle and
// hands descriptors back to the allocator one per cycle in arrival order.
module stk_pipe_dl
  import stk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [RT_PORTS_N-1:0] i_rt_vld,
  input  ptr_t [RT_PORTS_N-1:0] i_rt_ptr,
  output logic                  o_rt_rdy_r,
  input  logic                  i_init_busy,
  output logic                  o_dealloc_vld_r,
  output ptr_t                  o_dealloc_ptr_r,
  output logic                  o_busy_r
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [RT_PORTS_N-1:0] w_push;
  logic                  w_pop, w_empty;
  ptr_t                  w_head;
  logic [CW-1:0]         w_cnt_nxt;

  assign w_push = i_rt_vld & {RT_PORTS_N{o_rt_rdy_r}};
  assign w_pop  = (~w_empty | (|w_push)) & ~i_init_busy;

  stk_pipe_dl_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_push    (w_push),
    .i_wdata   (i_rt_ptr),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_empty   (w_empty),
    .o_cnt_nxt (w_cnt_nxt)
  );

  // Ready reserves room for a dual retire next cycle, this cycle's pop included.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      o_rt_rdy_r      <= 1'b0;
      o_dealloc_vld_r <= 1'b0;
      o_dealloc_ptr_r <= '0;
      o_busy_r        <= 1'b0;
    end else begin
      o_rt_rdy_r      <= (w_cnt_nxt <= CW'(DEPTH - 2));
      o_dealloc_vld_r <= w_pop;
      if (w_pop) o_dealloc_ptr_r <= w_head;
      o_busy_r        <= (w_cnt_nxt != '0) | w_pop;
    end
  end
endmodule

// File: tb/tb_stk_pipe_dl.sv
// Scoreboard bench for stk_pipe_dl: accepted retires queue expected returns.
module tb_stk_pipe_dl;
  import stk_pkg::*;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [1:0] i_rt_vld = '0;
  ptr_t [1:0] i_rt_ptr = '0;
  logic       i_init_busy = 1'b0;
  logic       o_rt_rdy_r, o_dealloc_vld_r, o_busy_r;
  ptr_t       o_dealloc_ptr_r;

  int   n_chk = 0, n_fail = 0;
  ptr_t exp_q[$];
  int   m_cnt = 0;
  logic m_rdy = 1'b0;

  always #5 clk = ~clk;

  stk_pipe_dl #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .i_rt_vld        (i_rt_vld),
    .i_rt_ptr        (i_rt_ptr),
    .o_rt_rdy_r      (o_rt_rdy_r),
    .i_init_busy     (i_init_busy),
    .o_dealloc_vld_r (o_dealloc_vld_r),
    .o_dealloc_ptr_r (o_dealloc_ptr_r),
    .o_busy_r        (o_busy_r)
  );

  function automatic ptr_t mk(input int b, input int l);
    return ptr_t'{bnk_id: bank_id_t'(b), line_id: line_id_t'(l)};
  endfunction

  task automatic set_in(input logic [1:0] v, input ptr_t p0, input ptr_t p1);
    i_rt_vld = v; i_rt_ptr[0] = p0; i_rt_ptr[1] = p1;
  endtask

  // Occupancy model: decides acceptance and pushes expected returns.
  always @(posedge clk) begin
    automatic int  np = 0;
    automatic int  nx;
    automatic bit  pop;
    if (!arst_n) begin
      m_cnt <= 0; m_rdy <= 1'b0; exp_q.delete();
    end else begin
      if (m_rdy) for (int p = 0; p < 2; p++)
        if (i_rt_vld[p]) begin exp_q.push_back(i_rt_ptr[p]); np++; end
      pop = ((m_cnt + np) != 0) && !i_init_busy;
      nx  = m_cnt + np - (pop ? 1 : 0);
      m_cnt <= nx;
      m_rdy <= (DEPTH - nx) >= 2;
    end
  end

  always @(negedge clk) begin
    if (o_dealloc_vld_r === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected got %h expected none", o_dealloc_ptr_r);
      end else begin
        automatic ptr_t e = exp_q.pop_front();
        if (o_dealloc_ptr_r !== e) begin
          n_fail++; $display("FAIL sb_order got %h expected %h", o_dealloc_ptr_r, e);
        end
      end
    end
  end

  task automatic test_reset;
    arst_n = 1'b0; set_in(2'b00, '0, '0); i_init_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_dealloc_vld_r, o_busy_r, o_rt_rdy_r} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b expected 000", {o_dealloc_vld_r, o_busy_r, o_rt_rdy_r});
    end
    n_chk++;
    if (o_dealloc_ptr_r !== ptr_t'(0)) begin
      n_fail++; $display("FAIL reset_ptr got %h expected 00", o_dealloc_ptr_r);
    end
    arst_n = 1'b1; #1;
    n_chk++;
    if (o_rt_rdy_r !== 1'b0) begin n_fail++; $display("FAIL rdy_cycle1 got %b expected 0", o_rt_rdy_r); end
    @(negedge clk);
    n_chk++;
    if (o_rt_rdy_r !== 1'b1) begin n_fail++; $display("FAIL rdy_cycle2 got %b expected 1", o_rt_rdy_r); end
  endtask

  task automatic test_single;
    set_in(2'b01, mk(1, 5), '0);
    @(negedge clk); set_in(2'b00, '0, '0);
    n_chk++;
    if ({o_dealloc_vld_r, o_busy_r} !== 2'b11 || o_dealloc_ptr_r !== mk(1, 5)) begin
      n_fail++; $display("FAIL single_n1 got vld=%b busy=%b ptr=%h expected 1 1 %h",
                         o_dealloc_vld_r, o_busy_r, o_dealloc_ptr_r, mk(1, 5));
    end
    @(negedge clk);
    n_chk++;
    if ({o_dealloc_vld_r, o_busy_r} !== 2'b00 || o_dealloc_ptr_r !== mk(1, 5)) begin
      n_fail++; $display("FAIL single_n2 got vld=%b busy=%b ptr=%h expected 0 0 %h (held)",
                         o_dealloc_vld_r, o_busy_r, o_dealloc_ptr_r, mk(1, 5));
    end
  endtask

  task automatic test_dual;
    ptr_t ex [2];
    ex[0] = mk(0, 3); ex[1] = mk(2, 7);
    @(negedge clk); set_in(2'b11, ex[0], ex[1]);
    @(negedge clk); set_in(2'b00, '0, '0);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (o_dealloc_vld_r !== 1'b1 || o_dealloc_ptr_r !== ex[k]) begin
        n_fail++; $display("FAIL dual_ret%0d got vld=%b ptr=%h expected 1 %h", k, o_dealloc_vld_r, o_dealloc_ptr_r, ex[k]);
      end
      @(negedge clk);
    end
    n_chk++;
    if (o_dealloc_vld_r !== 1'b0) begin n_fail++; $display("FAIL dual_idle got %b expected 0", o_dealloc_vld_r); end
  endtask

  task automatic test_full;
    ptr_t ex [4];
    logic rdy_ex [4];
    for (int k = 0; k < 4; k++) ex[k] = mk(k, 20 + k);
    rdy_ex[0] = 1'b0; rdy_ex[1] = 1'b1; rdy_ex[2] = 1'b1; rdy_ex[3] = 1'b1;
    @(negedge clk); i_init_busy = 1'b1; set_in(2'b11, ex[0], ex[1]);
    @(negedge clk);
    n_chk++;
    if (o_rt_rdy_r !== 1'b1) begin n_fail++; $display("FAIL full_half_rdy got %b expected 1", o_rt_rdy_r); end
    set_in(2'b11, ex[2], ex[3]);
    @(negedge clk);
    n_chk++;
    if (o_rt_rdy_r !== 1'b0) begin n_fail++; $display("FAIL full_rdy got %b expected 0", o_rt_rdy_r); end
    set_in(2'b11, mk(3, 60), mk(3, 61));
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (o_dealloc_vld_r !== 1'b0 || o_busy_r !== 1'b1) begin
        n_fail++; $display("FAIL full_stall got vld=%b busy=%b expected 0 1", o_dealloc_vld_r, o_busy_r);
      end
    end
    set_in(2'b00, '0, '0); i_init_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (o_dealloc_vld_r !== 1'b1 || o_dealloc_ptr_r !== ex[k] || o_rt_rdy_r !== rdy_ex[k]) begin
        n_fail++; $display("FAIL full_drain%0d got vld=%b ptr=%h rdy=%b expected 1 %h %b",
                           k, o_dealloc_vld_r, o_dealloc_ptr_r, o_rt_rdy_r, ex[k], rdy_ex[k]);
      end
    end
    @(negedge clk);
    n_chk++;
    if ({o_dealloc_vld_r, o_busy_r} !== 2'b00) begin
      n_fail++; $display("FAIL full_done got vld=%b busy=%b expected 0 0", o_dealloc_vld_r, o_busy_r);
    end
  endtask

  task automatic test_steady;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (o_rt_rdy_r !== 1'b1) begin n_fail++; $display("FAIL steady_rdy%0d got %b expected 1", i, o_rt_rdy_r); end
      if (i > 0) begin
        n_chk++;
        if (o_dealloc_vld_r !== 1'b1 || o_dealloc_ptr_r !== mk(i % 4, 30 + i - 1)) begin
          n_fail++; $display("FAIL steady_ret%0d got vld=%b ptr=%h expected 1 %h",
                             i, o_dealloc_vld_r, o_dealloc_ptr_r, mk(i % 4, 30 + i - 1));
        end
      end
      if (i < 20) set_in(2'b01, mk((i + 1) % 4, 30 + i), '0);
      else        set_in(2'b00, '0, '0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); i_init_busy = 1'b1; set_in(2'b11, mk(1, 40), mk(1, 41));
    @(negedge clk); set_in(2'b01, mk(1, 42), '0);
    @(negedge clk); set_in(2'b00, '0, '0); arst_n = 1'b0; i_init_busy = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1; #1;
    n_chk++;
    if (o_rt_rdy_r !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdy1 got %b expected 0", o_rt_rdy_r); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (o_dealloc_vld_r !== 1'b0 || o_busy_r !== 1'b0 || o_rt_rdy_r !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid_idle%0d got vld=%b busy=%b rdy=%b expected 0 0 1",
                           k, o_dealloc_vld_r, o_busy_r, o_rt_rdy_r);
      end
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 3 * DEPTH * 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (o_rt_rdy_r !== m_rdy) begin n_fail++; $display("FAIL wrap_rdy%0d got %b expected %b", i, o_rt_rdy_r, m_rdy); end
      i_init_busy = 1'($urandom_range(0, 1));
      if (i % 2 == 0) set_in(2'b01, mk($urandom_range(0, 3), $urandom_range(0, 63)), '0);
      else            set_in(2'b11, mk($urandom_range(0, 3), $urandom_range(0, 63)),
                                    mk($urandom_range(0, 3), $urandom_range(0, 63)));
    end
    @(negedge clk); set_in(2'b00, '0, '0); i_init_busy = 1'b0;
    repeat (2 * DEPTH + 4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_dual;
    test_full;
    test_steady;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stk_pipe_dl.md
STK_PIPE_DL -- requirements
Module: stk_pipe_dl

Interface
REQ-001 Parameter: DEPTH, default 4, return-buffer entries (power of two, >=2).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: arst_n  in  1  reset; synchronous and active-low.
REQ-004 Port: i_rt_vld  in  2  per-port descriptor retire request; port 0 is index 0.
REQ-005 Port: i_rt_ptr  in  2 x stk_pkg::ptr_t  retired descriptor per port.
REQ-006 Port: o_rt_rdy_r  out  1  registered ready; both ports may retire in the cycle it is high.
REQ-007 Port: i_init_busy  in  1  allocator stack initialisation in progress; suppresses issue.
REQ-008 Port: o_dealloc_vld_r  out  1  registered descriptor-return valid to allocator.
REQ-009 Port: o_dealloc_ptr_r  out  stk_pkg::ptr_t  registered descriptor being returned.
REQ-010 Port: o_busy_r  out  1  buffer non-empty or return in flight.

Function
REQ-011 Block SHALL buffer retired descriptors in a DEPTH-entry FIFO and return them to the allocator one per cycle, in FIFO order.
REQ-012 Retire accepted on port p iff i_rt_vld[p] & o_rt_rdy_r; i_rt_vld asserted while o_rt_rdy_r low SHALL be ignored (no state change).
REQ-013 o_rt_rdy_r SHALL be registered as (free slots after this cycle's push/pop) >= 2.
REQ-014 Both ports valid in one cycle: port 0 enqueued first, port 1 second (port 1 occupies the later slot).
REQ-015 Occupancy count width clog2(DEPTH)+1; SHALL saturate never: next = count + pushes(0..2) - pop(0..1); read/write pointers clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-016 Pop SHALL occur in a cycle iff count != 0 & ~i_init_busy; popped entry registered into o_dealloc_ptr_r with o_dealloc_vld_r=1 next cycle; otherwise o_dealloc_vld_r=0 next cycle.
REQ-017 Latency: retire at cycle N into empty buffer, i_init_busy low -> o_dealloc_vld_r high in cycle N+1 with that pointer (same-cycle write-through from port 0 when count==0).
REQ-018 When count==0 and both ports retire, port 0 issued at N+1, port 1 at N+2.
REQ-019 Simultaneous push and pop at full-minus-one/full boundaries SHALL be exact (pop frees slot same cycle for ready computation per REQ-013).
REQ-020 o_dealloc_ptr_r SHALL hold its last value when o_dealloc_vld_r low (no X to downstream).
REQ-021 o_busy_r = (next count != 0) | next o_dealloc_vld_r, registered.
REQ-022 i_init_busy high SHALL stall issue only; retires continue to be accepted up to capacity.

Reset
REQ-023 In any cycle with arst_n low: count=0, pointers=0, o_dealloc_vld_r=0, o_dealloc_ptr_r=0, o_busy_r=0, o_rt_rdy_r=0.
REQ-024 First cycle after arst_n high: o_rt_rdy_r=0; second cycle: o_rt_rdy_r=1 (registered from empty state).
REQ-025 Reset asserted mid-operation SHALL discard all buffered descriptors; no return issued after reset deasserts until a new retire.

Structure
REQ-026 stk_pkg SHALL own ptr_t, bank_id_t, line_id_t, RT_PORTS_N=2; DEPTH stays a module parameter.
REQ-027 FIFO storage and pointer logic SHALL be one sub-module, stk_pipe_dl_buf (2-write/1-read queue); issue register and ready logic in top.

Verification
REQ-028 Reset, then single retire ptr{bnk_id=1,line_id=5} at cycle 10 -> o_dealloc_vld_r=1, ptr {1,5} at cycle 11; o_busy_r low at cycle 12.
REQ-029 Dual retire {0,3} port0 and {2,7} port1 same cycle into empty buffer -> returns {0,3} then {2,7} on consecutive cycles.
REQ-030 i_init_busy high, 2 dual-retires (DEPTH=4) -> count=4, o_rt_rdy_r=0; further i_rt_vld ignored; drop i_init_busy -> four returns in enqueue order, o_rt_rdy_r=1 once count<=2.
REQ-031 Steady state one retire/cycle for 20 cycles -> 20 returns, order preserved, count never exceeds 1, o_rt_rdy_r never low.
REQ-032 arst_n low with 3 entries buffered -> no return after reset release; o_rt_rdy_r 0 then 1 as REQ-024.
REQ-033 Pointer wrap: 3*DEPTH alternating single/dual retires with random i_init_busy -> scoreboard shows no loss, duplication or reordering.
